// File: rtl/pulse_delay_bank.sv
// pulse_delay_bank: independent per-channel trigger -> delay -> pulse generators.
// Each channel watches for a rising edge on trig, counts down a latched delay,
// then drives pulse_out for a latched number of cycles and strobes done.
// mode selects whether a trigger arriving while busy is dropped (flagging miss)
// or restarts the sequence.
module pulse_delay_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*CNT_W-1:0] delay,
    input  logic [CHANNELS*CNT_W-1:0] width,
    input  logic                      miss_clr,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       miss
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A zero pulse width is promoted to a single-cycle pulse.
    function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w);
        return (w == '0) ? CNT_ONE : w;
    endfunction

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        // The latched delay lives directly in cnt; only the width needs its own
        // register because it is consumed after the delay phase.
        logic [CNT_W-1:0] wid_q, wid_d;
        logic             trig_q;
        logic             done_q, done_d;
        logic             miss_q, miss_d;
        logic             evt;
        logic             accept;
        logic [CNT_W-1:0] dly_in;
        logic [CNT_W-1:0] wid_in;

        assign dly_in = delay[gi*CNT_W +: CNT_W];
        assign wid_in = width[gi*CNT_W +: CNT_W];
        assign evt    = trig[gi] & ~trig_q;
        // Busy channels only accept a new event when retriggerable; an event on
        // the final pulse edge still counts as busy.
        assign accept = evt & ((state_q == ST_IDLE) | mode[gi]);

        // Next-state, counter and flag logic for one channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wid_d   = wid_q;
            done_d  = 1'b0;
            // A miss on the same edge as miss_clr wins.
            miss_d  = (miss_q & ~miss_clr) | (evt & ~accept);

            if (accept) begin
                wid_d = wid_in;
                if (dly_in == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = eff_width(wid_in);
                end else begin
                    state_d = ST_DELAY;
                    cnt_d   = dly_in;
                end
            end else begin
                case (state_q)
                    ST_DELAY: begin
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_PULSE;
                            cnt_d   = eff_width(wid_q);
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // Channel state registers; reset aborts any running sequence silently.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                wid_q   <= '0;
                trig_q  <= 1'b0;
                done_q  <= 1'b0;
                miss_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wid_q   <= wid_d;
                trig_q  <= trig[gi];
                done_q  <= done_d;
                miss_q  <= miss_d;
            end
        end

        assign pulse_out[gi] = (state_q == ST_PULSE);
        assign busy[gi]      = (state_q != ST_IDLE);
        assign done[gi]      = done_q;
        assign miss[gi]      = miss_q;
    end

endmodule

// File: tb/tb_pulse_delay_bank.sv
// Directed testbench for pulse_delay_bank (4 channels, 8-bit counters).
// Inputs change 1 time unit after each rising edge; outputs are checked at the
// same point, so each check reflects the state after the edge just taken.
module tb_pulse_delay_bank;

    localparam int CH = 4;
    localparam int CW = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [CH-1:0]    trig;
    logic [CH-1:0]    mode;
    logic [CH*CW-1:0] delay;
    logic [CH*CW-1:0] width;
    logic             miss_clr;
    logic [CH-1:0]    pulse_out;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    done;
    logic [CH-1:0]    miss;

    int n_chk  = 0;
    int n_fail = 0;

    pulse_delay_bank #(
        .CHANNELS (CH),
        .CNT_W    (CW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .trig      (trig),
        .mode      (mode),
        .delay     (delay),
        .width     (width),
        .miss_clr  (miss_clr),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .miss      (miss)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [3:0] p, input logic [3:0] b,
                           input logic [3:0] d, input logic [3:0] m);
        chk({tag, ".pulse"}, {28'd0, pulse_out}, {28'd0, p});
        chk({tag, ".busy"},  {28'd0, busy},      {28'd0, b});
        chk({tag, ".done"},  {28'd0, done},      {28'd0, d});
        chk({tag, ".miss"},  {28'd0, miss},      {28'd0, m});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_dw(input int ch, input int d, input int w);
        delay[ch*CW +: CW] = d[CW-1:0];
        width[ch*CW +: CW] = w[CW-1:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ep, eb, ed;
        RST_N    = 1'b0;
        trig     = '0;
        mode     = '0;
        delay    = '0;
        width    = '0;
        miss_clr = 1'b0;

        // Reset state
        step();
        step();
        exp_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        #2 RST_N = 1'b1;
        step();
        exp_out("idle", 4'h0, 4'h0, 4'h0, 4'h0);

        // Ch0 mode 0, D=3 W=2: pulse after edges k+3,k+4, done after k+5
        set_dw(0, 3, 2);
        for (int i = 0; i <= 6; i++) begin
            trig[0] = (i == 0);
            step();
            exp_out($sformatf("t1.k%0d", i),
                    (i == 3 || i == 4) ? 4'h1 : 4'h0,
                    (i <= 4) ? 4'h1 : 4'h0,
                    (i == 5) ? 4'h1 : 4'h0,
                    4'h0);
        end
        trig[0] = 1'b0;

        // Ch1 D=0 W=0: single-cycle pulse right after the trigger edge
        set_dw(1, 0, 0);
        for (int i = 0; i <= 2; i++) begin
            trig[1] = (i == 0);
            step();
            exp_out($sformatf("t2.k%0d", i),
                    (i == 0) ? 4'h2 : 4'h0,
                    (i == 0) ? 4'h2 : 4'h0,
                    (i == 1) ? 4'h2 : 4'h0,
                    4'h0);
        end

        // Ch1 mode 0, D=0 W=2, event on the final pulse edge: miss + done
        set_dw(1, 0, 2);
        for (int i = 0; i <= 2; i++) begin
            trig[1] = (i == 0 || i == 2);
            step();
            exp_out($sformatf("t2b.k%0d", i),
                    (i <= 1) ? 4'h2 : 4'h0,
                    (i <= 1) ? 4'h2 : 4'h0,
                    (i == 2) ? 4'h2 : 4'h0,
                    (i == 2) ? 4'h2 : 4'h0);
        end
        trig[1]  = 1'b0;
        miss_clr = 1'b1;
        step();
        miss_clr = 1'b0;
        exp_out("t2b.clr", 4'h0, 4'h0, 4'h0, 4'h0);

        // Ch2 mode 0, D=5 W=3, second trigger at k+2 dropped and flagged
        set_dw(2, 5, 3);
        for (int i = 0; i <= 9; i++) begin
            trig[2] = (i == 0 || i == 2);
            step();
            exp_out($sformatf("t3.k%0d", i),
                    (i >= 5 && i <= 7) ? 4'h4 : 4'h0,
                    (i <= 7) ? 4'h4 : 4'h0,
                    (i == 8) ? 4'h4 : 4'h0,
                    (i >= 2) ? 4'h4 : 4'h0);
        end
        trig[2]  = 1'b0;
        miss_clr = 1'b1;
        step();
        miss_clr = 1'b0;
        chk("t3.miss_clr", {28'd0, miss}, 32'h0);

        // Miss event and miss_clr on the same edge: set wins
        for (int i = 0; i <= 2; i++) begin
            trig[2]  = (i == 0 || i == 2);
            miss_clr = (i == 2);
            step();
        end
        trig[2]  = 1'b0;
        miss_clr = 1'b0;
        chk("t3.set_wins", {28'd0, miss}, 32'h4);
        chk("t3.set_busy", {28'd0, busy}, 32'h4);
        for (int i = 0; i < 7; i++) step();
        chk("t3.end_busy", {28'd0, busy}, 32'h0);
        chk("t3.end_miss", {28'd0, miss}, 32'h4);
        miss_clr = 1'b1;
        step();
        miss_clr = 1'b0;
        chk("t3.clr2", {28'd0, miss}, 32'h0);

        // Ch3 mode 1, D=4 W=2, retrigger at k+3 with D=6: pulse after k+9,k+10
        mode[3] = 1'b1;
        set_dw(3, 4, 2);
        for (int i = 0; i <= 12; i++) begin
            trig[3] = (i == 0 || i == 3);
            if (i == 3) set_dw(3, 6, 2);
            step();
            exp_out($sformatf("t4.k%0d", i),
                    (i == 9 || i == 10) ? 4'h8 : 4'h0,
                    (i <= 10) ? 4'h8 : 4'h0,
                    (i == 11) ? 4'h8 : 4'h0,
                    4'h0);
        end
        trig[3] = 1'b0;
        mode[3] = 1'b0;

        // All channels on one edge, D=1..4 W=1; bus changed after the edge
        for (int c = 0; c < CH; c++) set_dw(c, c + 1, 1);
        for (int i = 0; i <= 6; i++) begin
            trig = (i == 0) ? 4'hF : 4'h0;
            if (i == 1) begin
                for (int c = 0; c < CH; c++) set_dw(c, 255, 5);
            end
            step();
            for (int c = 0; c < CH; c++) begin
                ep[c] = (i == c + 1);
                eb[c] = (i <= c + 1);
                ed[c] = (i == c + 2);
            end
            exp_out($sformatf("t5.k%0d", i), ep, eb, ed, 4'h0);
        end

        // Reset mid-PULSE with miss set, trig held high across release
        set_dw(0, 1, 6);
        for (int i = 0; i <= 2; i++) begin
            trig[0] = (i == 0 || i == 2);
            step();
        end
        exp_out("t6.pre", 4'h1, 4'h1, 4'h0, 4'h1);
        #2 RST_N = 1'b0;
        #1;
        exp_out("t6.async", 4'h0, 4'h0, 4'h0, 4'h0);
        step();
        exp_out("t6.held", 4'h0, 4'h0, 4'h0, 4'h0);
        #2 RST_N = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            exp_out($sformatf("t6.k%0d", i),
                    (i >= 1 && i <= 6) ? 4'h1 : 4'h0,
                    (i <= 6) ? 4'h1 : 4'h0,
                    (i == 7) ? 4'h1 : 4'h0,
                    4'h0);
        end
        trig[0] = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
